// File: rtl/gate_bist_checker.sv
// Exhaustive self-test controller for one 2-input gate: sweeps {a,b}=00..11, samples the
// gate after a settle interval, and accumulates mismatches. Optional GATE_BIST_STOP_ON_FAIL_EN.
module gate_bist_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1000,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          PASSES        = 1,
    parameter int          ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_y,
    output logic             in_a,
    output logic             in_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [1:0]       o_dbg_state
);

    localparam int SW_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [7:0]      CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [SW_W-1:0] LAST_SWEEP = SW_W'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [SW_W-1:0]  r_sweep;
    logic [7:0]       r_cnt;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fail;
    logic             r_done;

    state_t           w_state_nxt;
    logic [1:0]       w_vec_nxt;
    logic [SW_W-1:0]  w_sweep_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic [3:0]       w_fail_nxt;
    logic             w_done_nxt;
    logic             w_mis;
    logic             w_stop;
    logic             w_busy;

    // start is a level request: honoured on any edge spent in IDLE or DONE, ignored otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= 2'd0;
            r_sweep <= '0;
            r_cnt   <= 8'd0;
            r_err   <= '0;
            r_fail  <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_sweep <= w_sweep_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_mis = (dut_y != TRUTH_TABLE[r_vec]);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mis;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_sweep_nxt = r_sweep;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        w_done_nxt  = r_done;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_err_nxt   = '0;
                    w_fail_nxt  = 4'd0;
                    w_vec_nxt   = 2'd0;
                    w_sweep_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            SAMPLE: begin
                if (w_mis) begin
                    w_fail_nxt[r_vec] = 1'b1;
                    if (r_err != {ERR_W{1'b1}}) begin
                        w_err_nxt = r_err + 1'b1;
                    end
                end
                if (w_stop || (r_vec == 2'd3 && r_sweep == LAST_SWEEP)) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_vec == 2'd3) begin
                    w_sweep_nxt = r_sweep + 1'b1;
                    w_vec_nxt   = 2'd0;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_state_nxt = SETTLE;
                end else begin
                    w_vec_nxt   = r_vec + 2'd1;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_state_nxt = SETTLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stimulus is gated by the registered state so the gate sees 00 whenever no run is active.
    assign w_busy      = (r_state == SETTLE) || (r_state == SAMPLE);
    assign busy        = w_busy;
    assign in_a        = w_busy & r_vec[1];
    assign in_b        = w_busy & r_vec[0];
    assign done        = r_done;
    assign pass        = r_done && (r_err == '0);
    assign err_count   = r_err;
    assign fail_vec    = r_fail;
    assign o_dbg_state = r_state;

endmodule
